rv32v_writeback_stage: RTL and testbench

//  Vector writeback stage: buffers per-beat lane results from the vector execute/mem

---
 rtl/rv32v_types_pkg.sv | 28 ++
 rtl/rv32v_writeback_stage_if.sv | 35 +++
 rtl/rv32v_wb_fifo.sv | 80 ++++++++
 rtl/rv32v_writeback_stage.sv | 114 +++++++++++
 tb/tb_rv32v_writeback_stage.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32v_types_pkg.sv
// Shared vector types and the writeback beat record carried from execute/mem into writeback.
package rv32v_types_pkg;
  localparam int NUM_LANES = 2;
  localparam int VL_WIDTH  = 4;
  localparam int OFFSET_W  = 4;

  typedef logic [31:0]         word_t;
  typedef logic [OFFSET_W-1:0] offset_t;
  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2
  } sew_t;

  typedef struct packed {
    word_t [NUM_LANES-1:0] wdata;
    logic  [4:0]           vd;
    offset_t               offset;
    sew_t                  eew;
    logic  [VL_WIDTH:0]    vl;
    logic                  wen;
    logic                  last;
  } wb_beat_t;

  function automatic logic [31:0] vd_onehot(input logic [4:0] vd);
    return 32'd1 << vd;
  endfunction
endpackage

// File: rtl/rv32v_writeback_stage_if.sv
// Execute-side beat handshake, control, register-file write port and hazard/completion outputs.
interface rv32v_writeback_stage_if;
  import rv32v_types_pkg::*;

  logic                     ex_valid;
  logic                     ex_ready;
  logic [NUM_LANES*32-1:0]  ex_wdata;
  logic [4:0]               ex_vd;
  offset_t                  ex_offset;
  sew_t                     ex_eew;
  logic [VL_WIDTH:0]        ex_vl;
  logic                     ex_wen;
  logic                     ex_last;
  logic                     flush;
  logic                     stall_wb;
  logic [NUM_LANES*32-1:0]  rf_w_data;
  logic [4:0]               rf_vd;
  logic                     rf_wen;
  offset_t                  rf_vd_offset;
  sew_t                     rf_eew;
  logic [VL_WIDTH:0]        rf_vl;
  logic [31:0]              pending_vd;
  logic                     wb_done;
  logic [4:0]               wb_done_vd;

  modport master (
    output ex_valid, ex_wdata, ex_vd, ex_offset, ex_eew, ex_vl, ex_wen, ex_last, flush, stall_wb,
    input  ex_ready, rf_w_data, rf_vd, rf_wen, rf_vd_offset, rf_eew, rf_vl, pending_vd, wb_done, wb_done_vd
  );

  modport slave (
    input  ex_valid, ex_wdata, ex_vd, ex_offset, ex_eew, ex_vl, ex_wen, ex_last, flush, stall_wb,
    output ex_ready, rf_w_data, rf_vd, rf_wen, rf_vd_offset, rf_eew, rf_vl, pending_vd, wb_done, wb_done_vd
  );
endinterface

// File: rtl/rv32v_wb_fifo.sv
// Beat buffer for writeback; head readable combinationally, pushed beat visible next cycle.
// Caller must not push when full; flush empties all entries on the clock edge.
module rv32v_wb_fifo
  import rv32v_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  wb_beat_t              i_beat,
  output wb_beat_t              o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH-1:0][4:0] o_entry_vd,
  output logic [DEPTH-1:0]      o_entry_wr
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rv32v_wb_fifo: DEPTH must be a power of two >= 2");
  end

  wb_beat_t [DEPTH-1:0] r_mem;
  logic [DEPTH-1:0]     r_vld;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
      end
      if (i_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: every consumer qualifies it with r_vld or the count.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_beat;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_entry_vd[i] = r_mem[i].vd;
      o_entry_wr[i] = r_vld[i] && r_mem[i].wen;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && o_full));
endmodule

// File: rtl/rv32v_writeback_stage.sv
// Vector writeback: buffers beats, drives the register-file port one beat per cycle (accept -> write 2 cycles),
// pulses completion, exports pending vd mask; ex_ready drops when the buffer is full or on flush.
module rv32v_writeback_stage
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES  = rv32v_types_pkg::NUM_LANES,
  parameter int FIFO_DEPTH = 2
) (
  input logic                    CLK,
  input logic                    nRST,
  rv32v_writeback_stage_if.slave wb
);
  if (NUM_LANES != rv32v_types_pkg::NUM_LANES) begin : g_bad_lanes
    $error("rv32v_writeback_stage: NUM_LANES must match rv32v_types_pkg");
  end

  wb_beat_t                   w_in_beat;
  wb_beat_t                   w_head;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic [FIFO_DEPTH-1:0][4:0] w_entry_vd;
  logic [FIFO_DEPTH-1:0]      w_entry_wr;
  logic [31:0]                w_pending;

  logic [NUM_LANES*32-1:0]    r_w_data;
  logic [4:0]                 r_vd;
  offset_t                    r_offset;
  sew_t                       r_eew;
  logic [VL_WIDTH:0]          r_vl;
  logic                       r_wen;
  logic                       r_done;
  logic [4:0]                 r_done_vd;

  always_comb begin
    w_in_beat        = '0;
    w_in_beat.wdata  = wb.ex_wdata;
    w_in_beat.vd     = wb.ex_vd;
    w_in_beat.offset = wb.ex_offset;
    w_in_beat.eew    = wb.ex_eew;
    w_in_beat.vl     = wb.ex_vl;
    w_in_beat.wen    = wb.ex_wen;
    w_in_beat.last   = wb.ex_last;
  end

  // nRST term keeps ready low while reset is held, even though the buffer already reads empty.
  assign wb.ex_ready = nRST && !w_full && !wb.flush;
  assign w_push      = wb.ex_valid && wb.ex_ready;
  assign w_pop       = !w_empty && !wb.stall_wb && !wb.flush;

  rv32v_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (nRST),
    .i_flush    (wb.flush),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_beat     (w_in_beat),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_entry_vd (w_entry_vd),
    .o_entry_wr (w_entry_wr)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_w_data  <= '0;
      r_vd      <= '0;
      r_offset  <= '0;
      r_eew     <= SEW_8;
      r_vl      <= '0;
      r_wen     <= 1'b0;
      r_done    <= 1'b0;
      r_done_vd <= '0;
    end else if (w_pop) begin
      r_w_data  <= w_head.wdata;
      r_vd      <= w_head.vd;
      r_offset  <= w_head.offset;
      r_eew     <= w_head.eew;
      r_vl      <= w_head.vl;
      r_wen     <= w_head.wen && (w_head.vl != '0);
      r_done    <= w_head.last;
      r_done_vd <= w_head.vd;
    end else begin
      r_wen  <= 1'b0;
      r_done <= 1'b0;
    end
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_entry_wr[i]) begin
        w_pending = w_pending | vd_onehot(w_entry_vd[i]);
      end
    end
    if (r_wen) begin
      w_pending = w_pending | vd_onehot(r_vd);
    end
  end

  assign wb.rf_w_data    = r_w_data;
  assign wb.rf_vd        = r_vd;
  assign wb.rf_wen       = r_wen;
  assign wb.rf_vd_offset = r_offset;
  assign wb.rf_eew       = r_eew;
  assign wb.rf_vl        = r_vl;
  assign wb.wb_done      = r_done;
  assign wb.wb_done_vd   = r_done_vd;
  assign wb.pending_vd   = w_pending;
endmodule

// File: tb/tb_rv32v_writeback_stage.sv
// Directed bench for rv32v_writeback_stage with a scoreboard of expected register-file writes and completions.
module tb_rv32v_writeback_stage;
  import rv32v_types_pkg::*;

  typedef struct {
    logic [63:0]       wdata;
    logic [4:0]        vd;
    offset_t           off;
    sew_t              eew;
    logic [VL_WIDTH:0] vl;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  rv32v_writeback_stage_if wb_if ();

  rv32v_writeback_stage #(
    .NUM_LANES  (NUM_LANES),
    .FIFO_DEPTH (2)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .wb   (wb_if)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  logic [4:0]  done_q[$];
  exp_t        mon_e;
  logic [4:0]  mon_done_vd;
  int          run_len  = 0;
  int          last_run = 0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write and completion pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (nRST) begin
      if (wb_if.rf_wen) begin
        run_len++;
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_write: rf_vd=%0d rf_vd_offset=%0d with no write outstanding",
                 wb_if.rf_vd, wb_if.rf_vd_offset);
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rf_w_data",    64'(wb_if.rf_w_data),    mon_e.wdata);
          check("rf_vd",        64'(wb_if.rf_vd),        64'(mon_e.vd));
          check("rf_vd_offset", 64'(wb_if.rf_vd_offset), 64'(mon_e.off));
          check("rf_eew",       64'(wb_if.rf_eew),       64'(mon_e.eew));
          check("rf_vl",        64'(wb_if.rf_vl),        64'(mon_e.vl));
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
      if (wb_if.wb_done) begin
        done_cnt++;
        n_checks++;
        assert (done_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_done: wb_done_vd=%0d with no completion outstanding", wb_if.wb_done_vd);
        end
        if (done_q.size() != 0) begin
          mon_done_vd = done_q.pop_front();
          check("wb_done_vd", 64'(wb_if.wb_done_vd), 64'(mon_done_vd));
        end
      end
    end
  end

  task automatic send(input logic [4:0] vd, input offset_t off, input logic [VL_WIDTH:0] vl,
                      input logic wen, input logic last, input bit expect_it, output int waits);
    logic [63:0] d;
    exp_t        e;
    d = {$urandom, $urandom};
    wb_if.ex_wdata  = d;
    wb_if.ex_vd     = vd;
    wb_if.ex_offset = off;
    wb_if.ex_eew    = vd[0] ? SEW_16 : SEW_32;
    wb_if.ex_vl     = vl;
    wb_if.ex_wen    = wen;
    wb_if.ex_last   = last;
    wb_if.ex_valid  = 1'b1;
    waits = 0;
    @(negedge CLK);
    while (!wb_if.ex_ready && waits < 20) begin
      waits++;
      @(negedge CLK);
    end
    n_checks++;
    assert (wb_if.ex_ready === 1'b1) else begin
      n_fail++;
      $error("FAIL send_timeout: ex_ready=%b after %0d cycles for vd=%0d", wb_if.ex_ready, waits, vd);
    end
    if (wb_if.ex_ready && expect_it) begin
      if (wen && vl != '0) begin
        e.wdata = d; e.vd = vd; e.off = off; e.eew = wb_if.ex_eew; e.vl = vl;
        exp_q.push_back(e);
      end
      if (last) done_q.push_back(vd);
    end
    @(posedge CLK);
    #1;
    wb_if.ex_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    wb_if.ex_valid  = 1'b0;
    wb_if.ex_wdata  = '0;
    wb_if.ex_vd     = '0;
    wb_if.ex_offset = '0;
    wb_if.ex_eew    = SEW_8;
    wb_if.ex_vl     = '0;
    wb_if.ex_wen    = 1'b0;
    wb_if.ex_last   = 1'b0;
    wb_if.flush     = 1'b0;
    wb_if.stall_wb  = 1'b0;

    // Reset state
    @(negedge CLK);
    check("rst_ex_ready",   64'(wb_if.ex_ready),   64'd0);
    check("rst_rf_wen",     64'(wb_if.rf_wen),     64'd0);
    check("rst_wb_done",    64'(wb_if.wb_done),    64'd0);
    check("rst_pending_vd", 64'(wb_if.pending_vd), 64'd0);
    check("rst_rf_vd",      64'(wb_if.rf_vd),      64'd0);
    check("rst_rf_w_data",  64'(wb_if.rf_w_data),  64'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("post_rst_ex_ready", 64'(wb_if.ex_ready), 64'd1);
    @(posedge CLK); #1;

    // Single beat: latency, done pulse, pending window
    send(5'd3, 4'd0, 5'd4, 1'b1, 1'b1, 1'b1, w);
    @(negedge CLK);
    check("t1_pending_buffered", 64'(wb_if.pending_vd), 64'h8);
    check("t1_rf_wen_early",     64'(wb_if.rf_wen),     64'd0);
    @(negedge CLK);
    check("t1_rf_wen",      64'(wb_if.rf_wen),     64'd1);
    check("t1_rf_vd",       64'(wb_if.rf_vd),      64'd3);
    check("t1_wb_done",     64'(wb_if.wb_done),    64'd1);
    check("t1_wb_done_vd",  64'(wb_if.wb_done_vd), 64'd3);
    check("t1_pending_out", 64'(wb_if.pending_vd), 64'h8);
    @(negedge CLK);
    check("t1_rf_wen_after",  64'(wb_if.rf_wen),     64'd0);
    check("t1_wb_done_after", 64'(wb_if.wb_done),    64'd0);
    check("t1_pending_clear", 64'(wb_if.pending_vd), 64'd0);
    @(posedge CLK); #1;

    // Back-to-back burst of 4 beats to vd=8
    idle(2);
    base = done_cnt;
    for (int k = 0; k < 4; k++) begin
      send(5'd8, offset_t'(k), 5'd8, 1'b1, (k == 3), 1'b1, w);
      check("t2_ready_waits", 64'(w), 64'd0);
    end
    idle(4);
    check("t2_wen_run_len", 64'(last_run),        64'd4);
    check("t2_done_count",  64'(done_cnt - base), 64'd1);

    // stall_wb with full buffer
    wb_if.stall_wb = 1'b1;
    send(5'd10, 4'd0, 5'd4, 1'b1, 1'b1, 1'b1, w);
    send(5'd11, 4'd0, 5'd4, 1'b1, 1'b1, 1'b1, w);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("t3_ex_ready", 64'(wb_if.ex_ready),   64'd0);
      check("t3_rf_wen",   64'(wb_if.rf_wen),     64'd0);
      check("t3_pending",  64'(wb_if.pending_vd), 64'h0000_0C00);
    end
    @(posedge CLK); #1;
    wb_if.stall_wb = 1'b0;
    idle(4);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // Flush with two buffered beats and a concurrent offer
    wb_if.stall_wb = 1'b1;
    send(5'd5, 4'd0, 5'd4, 1'b1, 1'b0, 1'b0, w);
    send(5'd5, 4'd1, 5'd4, 1'b1, 1'b1, 1'b0, w);
    wb_if.ex_vd    = 5'd7;
    wb_if.ex_wen   = 1'b1;
    wb_if.ex_valid = 1'b1;
    wb_if.flush    = 1'b1;
    @(negedge CLK);
    check("t4_ready_in_flush",   64'(wb_if.ex_ready),   64'd0);
    check("t4_pending_pre",      64'(wb_if.pending_vd), 64'h20);
    @(posedge CLK); #1;
    wb_if.flush    = 1'b0;
    wb_if.ex_valid = 1'b0;
    wb_if.stall_wb = 1'b0;
    @(negedge CLK);
    check("t4_rf_wen",  64'(wb_if.rf_wen),     64'd0);
    check("t4_wb_done", 64'(wb_if.wb_done),    64'd0);
    check("t4_pending", 64'(wb_if.pending_vd), 64'd0);
    @(posedge CLK); #1;
    idle(2);
    send(5'd6, 4'd2, 5'd4, 1'b1, 1'b1, 1'b1, w);
    idle(4);
    check("t4_after_flush_drained", 64'(exp_q.size()), 64'd0);

    // vl=0 beat: completion without a write
    send(5'd9, 4'd0, 5'd0, 1'b1, 1'b1, 1'b1, w);
    @(negedge CLK);
    check("t5_pending_buffered", 64'(wb_if.pending_vd), 64'h200);
    @(negedge CLK);
    check("t5_rf_wen",     64'(wb_if.rf_wen),     64'd0);
    check("t5_wb_done",    64'(wb_if.wb_done),    64'd1);
    check("t5_wb_done_vd", 64'(wb_if.wb_done_vd), 64'd9);
    check("t5_pending",    64'(wb_if.pending_vd), 64'd0);
    @(posedge CLK); #1;
    idle(2);

    // Asynchronous reset mid-burst
    wb_if.stall_wb = 1'b1;
    send(5'd12, 4'd0, 5'd4, 1'b1, 1'b0, 1'b0, w);
    send(5'd13, 4'd1, 5'd4, 1'b1, 1'b1, 1'b0, w);
    wb_if.ex_vd    = 5'd14;
    wb_if.ex_valid = 1'b1;
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check("t6_rf_vd",      64'(wb_if.rf_vd),      64'd0);
    check("t6_rf_w_data",  64'(wb_if.rf_w_data),  64'd0);
    check("t6_rf_vl",      64'(wb_if.rf_vl),      64'd0);
    check("t6_wb_done",    64'(wb_if.wb_done),    64'd0);
    check("t6_pending",    64'(wb_if.pending_vd), 64'd0);
    check("t6_ex_ready",   64'(wb_if.ex_ready),   64'd0);
    wb_if.ex_valid = 1'b0;
    wb_if.stall_wb = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("t6_ready_release",   64'(wb_if.ex_ready),   64'd1);
    check("t6_pending_release", 64'(wb_if.pending_vd), 64'd0);
    idle(5);

    check("end_write_queue_empty", 64'(exp_q.size()),  64'd0);
    check("end_done_queue_empty",  64'(done_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
